// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and sizing for the d_cache store buffer
package dmem_pkg;
  localparam int PC_W = 16;
  localparam int SB_DEPTH = 4;
  localparam int SB_CNT_W = $clog2(SB_DEPTH) + 1;
  typedef struct packed {
    logic [PC_W-1:0] addr;
    logic [PC_W-1:0] data;
  } sb_entry_t;
  typedef enum logic {RUN, FLUSH} sb_state_e;
endpackage

// File: rtl/sb_fifo.sv
// sb_fifo: circular store queue with head, full/empty and an oldest-first entry view
module sb_fifo import dmem_pkg::*; #(
  parameter int W = 2 * PC_W,
  parameter int DEPTH = SB_DEPTH,
  parameter int CW = SB_CNT_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [W-1:0]       din_i,
  output logic [W-1:0]       head_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [DEPTH*W-1:0] ent_o,
  output logic [DEPTH-1:0]   vld_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    rd_d = pop_i ? rd_q + AW'(1) : rd_q;
    wr_d = push_i ? wr_q + AW'(1) : wr_q;
    cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk_i)
    if (push_i) mem_q[wr_q] <= din_i;
  assign head_o = mem_q[rd_q];
  assign full_o = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  // slot k is the k-th oldest entry, so a higher k is a younger store
  for (genvar k = 0; k < DEPTH; k++) begin : g_ent
    assign ent_o[k*W +: W] = mem_q[rd_q + AW'(k)];
    assign vld_o[k] = cnt_q > CW'(k);
  end
endmodule

// File: rtl/d_store_buffer.sv
// d_store_buffer: store queue, load forwarding/stall and single-port arbitration for d_cache
// STORE_FWD_EN: loads hitting a buffered store take its data instead of stalling
module d_store_buffer import dmem_pkg::*; #(
  parameter int PC_BITS = PC_W,
  parameter int DEPTH = SB_DEPTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  input  logic               req_we_i,
  input  logic [PC_BITS-1:0] req_addr_i,
  input  logic [PC_BITS-1:0] req_wdata_i,
  output logic               req_ready_o,
  output logic               rsp_valid_o,
  output logic [PC_BITS-1:0] rsp_rdata_o,
  input  logic               flush_i,
  output logic               flush_done_o,
  output logic               empty_o,
  output logic               cache_en_o,
  output logic               cache_we_o,
  output logic [PC_BITS-1:0] cache_addr_o,
  output logic [PC_BITS-1:0] cache_wdata_o,
  input  logic [PC_BITS-1:0] cache_rdata_i
);
  localparam int W = 2 * PC_BITS;
  sb_state_e state_q, state_d;
  sb_entry_t din, head;
  logic [DEPTH*W-1:0] ent;
  logic [DEPTH-1:0] vld;
  logic run, full, empty, is_ld, hit, fwd, load_stall, acc, ld_rd, drain;
  logic [PC_BITS-1:0] fwd_data, rsp_rdata_q, rsp_rdata_d;
  logic rsp_valid_q, rsp_valid_d;
  assign din = '{addr: req_addr_i, data: req_wdata_i};
  sb_fifo #(.W(W), .DEPTH(DEPTH), .CW($clog2(DEPTH) + 1)) u_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(acc & req_we_i), .pop_i(drain),
    .din_i(din), .head_o(head), .full_o(full), .empty_o(empty),
    .ent_o(ent), .vld_o(vld)
  );
  always_comb begin
    hit = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++)
      if (vld[k] && ent[k*W+PC_BITS +: PC_BITS] == req_addr_i) begin
        hit = 1'b1;
        fwd_data = ent[k*W +: PC_BITS];
      end
  end
  assign is_ld = req_valid_i & ~req_we_i;
`ifdef STORE_FWD_EN
  assign load_stall = 1'b0;
  assign fwd = is_ld & hit;
`else
  assign load_stall = is_ld & hit;
  assign fwd = 1'b0;
`endif
  // reset also blocks acceptance so the cache port stays idle while rst_i is high
  assign req_ready_o = run & ~full & ~load_stall & ~rst_i;
  assign acc = req_valid_i & req_ready_o;
  assign ld_rd = acc & ~req_we_i & ~fwd;
  assign drain = ~ld_rd & ~empty;
  always_comb begin
    cache_en_o = ld_rd | drain;
    cache_we_o = drain;
    cache_addr_o = ld_rd ? req_addr_i : drain ? head.addr : '0;
    cache_wdata_o = drain ? head.data : '0;
  end
  always_comb begin
    rsp_valid_d = acc & ~req_we_i;
    rsp_rdata_d = rsp_valid_d ? (fwd ? fwd_data : cache_rdata_i) : rsp_rdata_q;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign empty_o = empty;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state_q <= RUN;
    else state_q <= state_d;
  always_comb state_d = (state_q == RUN) ? (flush_i ? FLUSH : RUN) : (empty ? RUN : FLUSH);
  always_comb begin
    run = state_q == RUN;
    flush_done_o = (state_q == FLUSH) & empty;
  end
endmodule

// File: tb/tb_d_store_buffer.sv
// tb_d_store_buffer: directed vector table plus randomized run against an architectural memory model
module tb_d_store_buffer;
`ifdef STORE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int DEPTH = 4;
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic req_valid_i = 0, req_we_i = 0, flush_i = 0;
  logic [15:0] req_addr_i = 0, req_wdata_i = 0;
  logic req_ready_o, rsp_valid_o, flush_done_o, empty_o, cache_en_o, cache_we_o;
  logic [15:0] rsp_rdata_o, cache_addr_o, cache_wdata_o, cache_rdata_i;
  logic [15:0] cmem [256];
  logic [15:0] arch [256];
  int total = 0, bad = 0;

  typedef struct {logic [15:0] a, d;} st_t;
  st_t q[$];
  bit m_flush;

  typedef struct {
    logic v, w; logic [15:0] a, d; logic fl;
    logic rdy, en, we; logic [15:0] ca, cd; logic done, rv; logic [15:0] rd;
  } vec_t;
  vec_t tbl [20];

  d_store_buffer dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_ready_o(req_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .flush_i(flush_i),
    .flush_done_o(flush_done_o), .empty_o(empty_o), .cache_en_o(cache_en_o),
    .cache_we_o(cache_we_o), .cache_addr_o(cache_addr_o), .cache_wdata_o(cache_wdata_o),
    .cache_rdata_i(cache_rdata_i)
  );

  always #5 clk_i = ~clk_i;
  assign cache_rdata_i = cmem[cache_addr_o[7:0]];
  always @(posedge clk_i) if (cache_en_o && cache_we_o) cmem[cache_addr_o[7:0]] <= cache_wdata_o;

  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic chk1(input string n, input logic act, input logic exp);
    chk(n, 16'(act), 16'(exp));
  endtask

  task automatic drive(input logic v, input logic w, input logic [15:0] a, input logic [15:0] d, input logic fl);
    req_valid_i = v; req_we_i = w; req_addr_i = a; req_wdata_i = d; flush_i = fl;
  endtask

  function automatic vec_t V(input logic v, w, input logic [15:0] a, d, input logic fl,
                             input logic rdy, en, we, input logic [15:0] ca, cd,
                             input logic done, rv, input logic [15:0] rd);
    V = '{v, w, a, d, fl, rdy, en, we, ca, cd, done, rv, rd};
  endfunction

  // one cycle checked against the model: pending-store queue plus architectural memory
  task automatic mcyc(input logic v, input logic w, input logic [15:0] a, input logic [15:0] d, input logic fl);
    bit hit, er, acc, ldrd, dr, ed, ev;
    logic [15:0] evd;
    drive(v, w, a, d, fl);
    @(negedge clk_i);
    hit = 0;
    foreach (q[i]) if (q[i].a == a) hit = 1;
    er = !m_flush && q.size() < DEPTH && !(!FWD && v && !w && hit);
    chk1("m_ready", req_ready_o, er);
    acc = v && er;
    ldrd = acc && !w && !(FWD && hit);
    dr = !ldrd && q.size() > 0;
    chk1("m_en", cache_en_o, ldrd || dr);
    chk1("m_we", cache_we_o, dr);
    chk("m_addr", cache_addr_o, dr ? q[0].a : ldrd ? a : 16'h0);
    chk("m_wdata", cache_wdata_o, dr ? q[0].d : 16'h0);
    chk1("m_empty", empty_o, q.size() == 0);
    ed = m_flush && q.size() == 0;
    chk1("m_done", flush_done_o, ed);
    if (dr) void'(q.pop_front());
    ev = acc && !w;
    evd = arch[a[7:0]];
    if (acc && w) begin
      q.push_back('{a, d});
      arch[a[7:0]] = d;
    end
    if (!m_flush && fl) m_flush = 1;
    else if (ed) m_flush = 0;
    @(posedge clk_i); #1;
    chk1("m_rvalid", rsp_valid_o, ev);
    if (ev) chk("m_rdata", rsp_rdata_o, evd);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) cmem[i] = 16'(i) ^ 16'h5A5A;
    tbl[0]  = V(1,1,16'h40,16'h0A01,0, 1,0,0,16'h00,16'h0000, 0,0,16'h0);
    tbl[1]  = V(1,1,16'h41,16'h0A02,0, 1,1,1,16'h40,16'h0A01, 0,0,16'h0);
    tbl[2]  = V(1,1,16'h42,16'h0A03,0, 1,1,1,16'h41,16'h0A02, 0,0,16'h0);
    tbl[3]  = V(0,0,16'h00,16'h0000,0, 1,1,1,16'h42,16'h0A03, 0,0,16'h0);
    tbl[4]  = V(0,0,16'h00,16'h0000,0, 1,0,0,16'h00,16'h0000, 0,0,16'h0);
    tbl[5]  = V(1,1,16'h10,16'hBEEF,0, 1,0,0,16'h00,16'h0000, 0,0,16'h0);
    tbl[6]  = FWD ? V(1,0,16'h10,16'h0,0, 1,1,1,16'h10,16'hBEEF, 0,1,16'hBEEF)
                  : V(1,0,16'h10,16'h0,0, 0,1,1,16'h10,16'hBEEF, 0,0,16'h0);
    tbl[7]  = V(1,0,16'h10,16'h0000,0, 1,1,0,16'h10,16'h0000, 0,1,16'hBEEF);
    tbl[8]  = V(1,1,16'h30,16'h1111,0, 1,0,0,16'h00,16'h0000, 0,0,16'h0);
    tbl[9]  = V(1,1,16'h30,16'h2222,0, 1,1,1,16'h30,16'h1111, 0,0,16'h0);
    tbl[10] = FWD ? V(1,0,16'h30,16'h0,0, 1,1,1,16'h30,16'h2222, 0,1,16'h2222)
                  : V(1,0,16'h30,16'h0,0, 0,1,1,16'h30,16'h2222, 0,0,16'h0);
    tbl[11] = V(1,0,16'h30,16'h0000,0, 1,1,0,16'h30,16'h0000, 0,1,16'h2222);
    tbl[12] = V(1,0,16'h55,16'h0000,0, 1,1,0,16'h55,16'h0000, 0,1,16'h5A0F);
    tbl[13] = V(1,1,16'h60,16'h1234,0, 1,0,0,16'h00,16'h0000, 0,0,16'h0);
    tbl[14] = V(0,0,16'h00,16'h0000,1, 1,1,1,16'h60,16'h1234, 0,0,16'h0);
    tbl[15] = V(1,1,16'h61,16'h9999,0, 0,0,0,16'h00,16'h0000, 1,0,16'h0);
    tbl[16] = V(0,0,16'h00,16'h0000,0, 1,0,0,16'h00,16'h0000, 0,0,16'h0);
    tbl[17] = V(0,0,16'h00,16'h0000,1, 1,0,0,16'h00,16'h0000, 0,0,16'h0);
    tbl[18] = V(0,0,16'h00,16'h0000,0, 0,0,0,16'h00,16'h0000, 1,0,16'h0);
    tbl[19] = V(1,0,16'h61,16'h0000,0, 1,1,0,16'h61,16'h0000, 0,1,16'h5A3B);
    #3;
    chk1("rst_rvalid", rsp_valid_o, 1'b0);
    chk("rst_rdata", rsp_rdata_o, 16'h0);
    chk1("rst_done", flush_done_o, 1'b0);
    chk1("rst_empty", empty_o, 1'b1);
    chk1("rst_en", cache_en_o, 1'b0);
    @(posedge clk_i); #1 rst_i = 0;
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].fl);
      @(negedge clk_i);
      chk1($sformatf("v%0d_ready", i), req_ready_o, tbl[i].rdy);
      chk1($sformatf("v%0d_en", i), cache_en_o, tbl[i].en);
      chk1($sformatf("v%0d_we", i), cache_we_o, tbl[i].we);
      chk($sformatf("v%0d_addr", i), cache_addr_o, tbl[i].ca);
      chk($sformatf("v%0d_wdata", i), cache_wdata_o, tbl[i].cd);
      chk1($sformatf("v%0d_done", i), flush_done_o, tbl[i].done);
      @(posedge clk_i); #1;
      chk1($sformatf("v%0d_rvalid", i), rsp_valid_o, tbl[i].rv);
      if (tbl[i].rv) chk($sformatf("v%0d_rdata", i), rsp_rdata_o, tbl[i].rd);
    end
    // async reset with a store pending and a load response showing
    drive(1, 1, 16'h70, 16'h7777, 0);
    @(posedge clk_i); #1;
    drive(1, 0, 16'h81, 16'h0, 0);
    @(posedge clk_i); #1;
    chk1("pre_rst_rvalid", rsp_valid_o, 1'b1);
    chk1("pre_rst_empty", empty_o, 1'b0);
    #2 rst_i = 1;
    #1;
    chk1("arst_empty", empty_o, 1'b1);
    chk1("arst_en", cache_en_o, 1'b0);
    chk1("arst_rvalid", rsp_valid_o, 1'b0);
    drive(0, 0, 16'h0, 16'h0, 0);
    @(posedge clk_i); @(posedge clk_i); #1 rst_i = 0;
    for (int i = 0; i < 256; i++) arch[i] = cmem[i];
    q.delete();
    m_flush = 0;
    for (int n = 0; n < 3000; n++)
      mcyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 16'h0090 + 16'($urandom_range(0, 7)),
           16'($urandom), $urandom_range(0, 39) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
